// File: rtl/aes_const.sv
// AES geometry constants shared by the cipher datapath and key schedule.
package aes_const;

  localparam int unsigned Nb = 4;
  localparam int unsigned Nr = 10;
  localparam int unsigned Nk = 4;

endpackage

// File: rtl/aes_wire.sv
// Shared AES controller types and the forward S-box.
package aes_wire;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Forward S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[11'(2047 - 8 * int'(b)) -: 8];
  endfunction

endpackage

// File: rtl/aes_add_round_key.sv
// Add-round-key: column j of the state is XORed with round-key word j.
module aes_add_round_key
  import aes_const::*;
(
  input  logic [127:0] st,
  input  logic [31:0]  rk [Nb],
  output logic [127:0] st_out
);

  localparam int unsigned JW = (Nb > 1) ? $clog2(Nb) : 1;

  // Word j covers state bytes 4j..4j+3, row 0 in the top byte
  always_comb begin
    st_out = st;
    for (int j = 0; j < int'(Nb); j++) begin
      st_out[7'(127 - 32 * j) -: 32] = st[7'(127 - 32 * j) -: 32] ^ rk[JW'(j)];
    end
  end

endmodule

// File: rtl/aes_round_fn.sv
// One AES encryption round: SubBytes, ShiftRows, MixColumns (skipped when last), AddRoundKey.
module aes_round_fn
  import aes_const::*;
  import aes_wire::*;
(
  input  logic [127:0] st,
  input  logic [31:0]  rk [Nb],
  input  logic         last,
  output logic [127:0] st_out
);

  logic [7:0]   sb_b [16];
  logic [7:0]   sr_b [16];
  logic [7:0]   mc_b [16];
  logic [127:0] mix_st;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes, then ShiftRows: row r of column c comes from column (c+r) mod 4
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      sb_b[4'(k)] = sbox(st[7'(127 - 8 * k) -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_b[4'(4 * c + r)] = sb_b[4'(4 * ((c + r) % 4) + r)];
      end
    end
  end

  // MixColumns on each column; the final round passes ShiftRows output through
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mc_b[4'(4*c)]   = xt(sr_b[4'(4*c)]) ^ xt(sr_b[4'(4*c+1)]) ^ sr_b[4'(4*c+1)]
                      ^ sr_b[4'(4*c+2)] ^ sr_b[4'(4*c+3)];
      mc_b[4'(4*c+1)] = sr_b[4'(4*c)] ^ xt(sr_b[4'(4*c+1)]) ^ xt(sr_b[4'(4*c+2)])
                      ^ sr_b[4'(4*c+2)] ^ sr_b[4'(4*c+3)];
      mc_b[4'(4*c+2)] = sr_b[4'(4*c)] ^ sr_b[4'(4*c+1)] ^ xt(sr_b[4'(4*c+2)])
                      ^ xt(sr_b[4'(4*c+3)]) ^ sr_b[4'(4*c+3)];
      mc_b[4'(4*c+3)] = xt(sr_b[4'(4*c)]) ^ sr_b[4'(4*c)] ^ sr_b[4'(4*c+1)]
                      ^ sr_b[4'(4*c+2)] ^ xt(sr_b[4'(4*c+3)]);
    end
    mix_st = '0;
    for (int k = 0; k < 16; k++) begin
      mix_st[7'(127 - 8 * k) -: 8] = last ? sr_b[4'(k)] : mc_b[4'(k)];
    end
  end

  aes_add_round_key u_ark (
    .st     (mix_st),
    .rk     (rk),
    .st_out (st_out)
  );

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption controller: one round per clock, valid/ready in and out.
module aes_round_ctrl
  import aes_const::*;
  import aes_wire::*;
#(
  parameter int unsigned Nr = aes_const::Nr
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          kexp_valid,
  input  logic [31:0]   KExp [Nb*(Nr+1)],
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic [3:0]    round_idx,
  output logic          busy
);

  localparam int unsigned NW = Nb * (Nr + 1);
  localparam int unsigned IW = $clog2(NW);
  localparam int unsigned JW = (Nb > 1) ? $clog2(Nb) : 1;

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic         ov_q, ov_d;

  logic [31:0]  rk0 [Nb];
  logic [31:0]  rkr [Nb];
  logic [127:0] ark0_out;
  logic [127:0] rf_out;
  logic         last;

  assign last      = (rnd_q == 4'(Nr));
  assign in_ready  = (fsm_q == IDLE) && kexp_valid && !rst;
  assign busy      = (fsm_q != IDLE);
  assign out_valid = ov_q;
  assign out_data  = st_q;
  assign round_idx = rnd_q;

  // Round-0 key for the whitening step and the key for the current round
  always_comb begin
    for (int j = 0; j < int'(Nb); j++) begin
      rk0[JW'(j)] = KExp[IW'(j)];
      rkr[JW'(j)] = KExp[IW'(int'(rnd_q) * int'(Nb) + j)];
    end
  end

  aes_add_round_key u_ark0 (
    .st     (in_data),
    .rk     (rk0),
    .st_out (ark0_out)
  );

  aes_round_fn u_round (
    .st     (st_q),
    .rk     (rkr),
    .last   (last),
    .st_out (rf_out)
  );

  // Controller state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= IDLE;
      rnd_q <= '0;
      st_q  <= '0;
      ov_q  <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      st_q  <= st_d;
      ov_q  <= ov_d;
    end
  end

  // Next-state: accept, iterate rounds, hold ciphertext until consumed
  always_comb begin
    fsm_d = fsm_q;
    rnd_d = rnd_q;
    st_d  = st_q;
    ov_d  = ov_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          st_d  = ark0_out;
          rnd_d = 4'd1;
          fsm_d = RUN;
        end
      end
      RUN: begin
        st_d = rf_out;
        if (last) begin
          fsm_d = DONE;
          ov_d  = 1'b1;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        if (ov_q && out_ready) begin
          ov_d  = 1'b0;
          rnd_d = '0;
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

endmodule
